grasspopper_dec: RTL and testbench

GRASSPOPPER_DEC -- requirements
Module: grasspopper_dec

---
 rtl/grasspopper_dec.sv | 165 ++++++++++++++++
 tb/tb_grasspopper_dec.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/grasspopper_dec.sv
// Iterative Kuznyechik (GOST R 34.12-2015) block decryptor: serial L^-1, single-cycle S^-1.
// Optional GRASSPOPPER_DEC_ZEROIZE_EN adds a zeroize input and clears the key store on reset.

module sbox_inv (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Forward pi table, entry 0 in the most significant byte; the inverse is found by matching.
  localparam logic [2047:0] PI = {
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 256; i++)
      if (PI[8*(255-i) +: 8] == din) dout = i[7:0];
  end
endmodule

module grasspopper_dec (
  input  logic         clk,
  input  logic         rst,
`ifdef GRASSPOPPER_DEC_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_we,
  input  logic [3:0]   key_idx,
  input  logic [127:0] key_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_o,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, INVL, SUB, DONE} state_t;

  // l coefficients c0..c15, c0 in the least significant byte.
  localparam logic [127:0] LC = {
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  state_t       fsm;
  logic [127:0] keys [10];
  logic [127:0] st;
  logic [127:0] sub;
  logic [127:0] rkey;
  logic [3:0]   round;
  logic [3:0]   cnt;
  logic [7:0]   lin;
  logic         key_ok;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // R^-1 feedback byte: l applied to (a14..a0, a15).
  always_comb begin
    lin = gf_mul(st[127:120], LC[127:120]);
    for (int unsigned j = 0; j < 15; j++)
      lin ^= gf_mul(st[8*(14-j) +: 8], LC[8*j +: 8]);
  end

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    sbox_inv u_sbox (.din(st[8*g +: 8]), .dout(sub[8*g +: 8]));
  end

  assign rkey   = keys[round - 4'd1];
  assign key_ok = key_we && (fsm == IDLE) && (key_idx <= 4'd9);

`ifdef GRASSPOPPER_DEC_ZEROIZE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         keys <= '{default: '0};
    else if (zeroize) keys <= '{default: '0};
    else if (key_ok)  keys[key_idx] <= key_i;
  end
`else
  always_ff @(posedge clk) begin
    if (key_ok) keys[key_idx] <= key_i;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      st        <= '0;
      round     <= '0;
      cnt       <= '0;
      data_o    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef GRASSPOPPER_DEC_ZEROIZE_EN
    end else if (zeroize) begin
      fsm       <= IDLE;
      st        <= '0;
      round     <= '0;
      cnt       <= '0;
      data_o    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          st       <= data_i ^ keys[9];
          round    <= 4'd9;
          cnt      <= '0;
          fsm      <= INVL;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        INVL: begin
          st  <= {st[119:0], lin};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) fsm <= SUB;
        end
        SUB: begin
          st <= sub ^ rkey;
          if (round == 4'd1) begin
            fsm       <= DONE;
            data_o    <= sub ^ rkey;
            out_valid <= 1'b1;
          end else begin
            round <= round - 4'd1;
            fsm   <= INVL;
          end
        end
        DONE: if (out_ready) begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grasspopper_dec.sv
// Directed + randomized bench for grasspopper_dec against a byte-level GOST decryption model.
module tb_grasspopper_dec;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_we = 1'b0;
  logic [3:0]   key_idx = '0;
  logic [127:0] key_i = '0;
  logic         in_valid = 1'b0;
  logic [127:0] data_i = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [127:0] data_o;
`ifdef GRASSPOPPER_DEC_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int pi_tab [256] = '{
    252,238,221,17,207,110,49,22,251,196,250,218,35,197,4,77,
    233,119,240,219,147,46,153,186,23,54,241,187,20,205,95,193,
    249,24,101,90,226,92,239,33,129,28,60,66,139,1,142,79,
    5,132,2,174,227,106,143,160,6,11,237,152,127,212,211,31,
    235,52,44,81,234,200,72,171,242,42,104,162,253,58,206,204,
    181,112,14,86,8,12,118,18,191,114,19,71,156,183,93,135,
    21,161,150,41,16,123,154,199,243,145,120,111,157,158,178,177,
    50,117,25,61,255,53,138,126,109,84,198,128,195,189,13,87,
    223,245,36,169,62,168,67,201,215,121,214,246,124,34,185,3,
    224,15,236,222,122,148,176,188,220,232,40,80,78,51,10,74,
    167,151,96,115,30,0,98,68,26,184,56,130,100,159,38,65,
    173,69,70,146,39,94,85,47,140,163,165,125,105,213,149,59,
    7,88,179,64,134,172,29,247,48,55,107,228,136,217,231,137,
    225,27,131,73,76,63,248,254,141,83,170,144,202,216,133,97,
    32,113,103,164,45,43,9,91,203,155,37,208,190,229,108,82,
    89,166,116,210,230,244,180,192,209,102,175,194,57,75,99,182};
  int sinv [256];
  int coef [16] = '{148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1};

  logic [127:0] rfc_k [10] = '{
    128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043};
  localparam logic [127:0] RFC_C = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] RFC_P = 128'h1122334455667700ffeeddccbbaa9988;

  logic [127:0] mk [10];

  always #5 clk = ~clk;

  grasspopper_dec dut (
    .clk(clk), .rst(rst),
`ifdef GRASSPOPPER_DEC_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_we(key_we), .key_idx(key_idx), .key_i(key_i),
    .in_valid(in_valid), .in_ready(in_ready), .data_i(data_i),
    .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o),
    .busy(busy));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Carry-less product, then reduction by x^8+x^7+x^6+x+1.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (b & (1 << i)) p ^= a << i;
    for (int i = 14; i >= 8; i--) if (p & (1 << i)) p ^= 'h1C3 << (i - 8);
    return p;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] c);
    logic [127:0] x;
    int acc;
    x = c ^ mk[9];
    for (int r = 9; r >= 1; r--) begin
      for (int n = 0; n < 16; n++) begin
        acc = gmul(int'(x[127:120]), coef[15]);
        for (int j = 0; j < 15; j++) acc ^= gmul(int'(x[8*(14-j) +: 8]), coef[j]);
        x = {x[119:0], acc[7:0]};
      end
      for (int k = 0; k < 16; k++) begin
        acc = sinv[int'(x[8*k +: 8])];
        x[8*k +: 8] = acc[7:0];
      end
      x ^= mk[r-1];
    end
    return x;
  endfunction

  task automatic write_key(input logic [3:0] idx, input logic [127:0] k);
    @(negedge clk);
    key_we = 1'b1; key_idx = idx; key_i = k;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic load_rfc();
    for (int i = 0; i < 10; i++) begin
      write_key(4'(i), rfc_k[i]);
      mk[i] = rfc_k[i];
    end
  endtask

  // One block: accept (optionally with a K10 write), keep in_valid asserted with junk while busy,
  // optionally attempt a key write mid-run, hold the result, then acknowledge.
  task automatic run_block(input logic [127:0] c, input logic [127:0] exp, input int hold,
                           input bit mid_key, input bit acc_key, input logic [127:0] newk);
    int lat;
    logic [127:0] held;
    @(negedge clk);
    check("in_ready_idle", 128'(in_ready), 128'(1));
    in_valid = 1'b1; data_i = c;
    if (acc_key) begin key_we = 1'b1; key_idx = 4'd9; key_i = newk; end
    @(posedge clk); #1;
    key_we = 1'b0;
    data_i = rand128();
    check("busy_after_accept", 128'({busy, in_ready}), 128'(2'b10));
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (mid_key && lat == 50) begin key_we = 1'b1; key_idx = 4'd3; key_i = rand128(); end
      if (mid_key && lat == 51) key_we = 1'b0;
    end
    check("latency", 128'(lat), 128'(153));
    check("plaintext", data_o, exp);
    held = data_o;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold", {out_valid, in_ready, busy, data_o[124:0]}, {3'b101, held[124:0]});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_ack", 128'({out_valid, busy, in_ready}), 128'(3'b001));
  endtask

  initial begin
    logic [127:0] c, k, exp;
    for (int i = 0; i < 256; i++) sinv[pi_tab[i]] = i;
    for (int i = 0; i < 10; i++) mk[i] = '0;

    #1 rst = 1'b0;
    #20;
    check("reset_ctrl", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    check("reset_data", data_o, '0);
    @(negedge clk); rst = 1'b1;

    load_rfc();
    run_block(RFC_C, RFC_P, 20, 1'b0, 1'b0, '0);

    // Out-of-range index in IDLE and a mid-run write must both be dropped.
    write_key(4'd12, rand128());
    run_block(RFC_C, RFC_P, 0, 1'b1, 1'b0, '0);
    run_block(RFC_C, RFC_P, 1, 1'b0, 1'b0, '0);

    // Reset at cycle 80 of a decryption.
    @(negedge clk); in_valid = 1'b1; data_i = rand128();
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (79) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ctrl", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    check("rst_mid_data", data_o, '0);
    @(negedge clk); rst = 1'b1;
`ifdef GRASSPOPPER_DEC_ZEROIZE_EN
    for (int i = 0; i < 10; i++) mk[i] = '0;
    c = rand128();
    run_block(c, ref_dec(c), 0, 1'b0, 1'b0, '0);
    load_rfc();
`endif
    run_block(RFC_C, RFC_P, 2, 1'b0, 1'b0, '0);

    // Key write coinciding with accept: block uses the old K10, write still lands.
    c = rand128(); k = rand128(); exp = ref_dec(c);
    run_block(c, exp, 0, 1'b0, 1'b1, k);
    mk[9] = k;
    c = rand128();
    run_block(c, ref_dec(c), 0, 1'b0, 1'b0, '0);

    for (int n = 0; n < 4; n++) begin
      k = rand128();
      write_key(4'($urandom_range(0, 9)), k);
      mk[key_idx] = k;
      c = rand128();
      run_block(c, ref_dec(c), $urandom_range(0, 4), 1'b0, 1'b0, '0);
    end

`ifdef GRASSPOPPER_DEC_ZEROIZE_EN
    @(negedge clk); in_valid = 1'b1; data_i = rand128();
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); zeroize = 1'b1;
    @(posedge clk); #1 zeroize = 1'b0;
    check("zeroize_ctrl", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    check("zeroize_data", data_o, '0);
    for (int i = 0; i < 10; i++) mk[i] = '0;
    c = rand128();
    run_block(c, ref_dec(c), 1, 1'b0, 1'b0, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
